// File: rtl/unpool2x_upsampler_if.sv
// Memory-side bus of the 2x2 unpool upsampler.
// master: pooled read port (pool_*) + output write port (up_*).
interface unpool2x_upsampler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PA_W       = 11,
  parameter int UA_W       = 13
);
  logic [PA_W-1:0]              pool_addr;
  logic                         pool_en;
  logic signed [DATA_WIDTH-1:0] pool_q;
  logic [UA_W-1:0]              up_addr;
  logic                         up_en;
  logic                         up_we;
  logic signed [DATA_WIDTH-1:0] up_d;

  modport master (
    output pool_addr, pool_en,
    input  pool_q,
    output up_addr, up_en, up_we, up_d
  );

  modport slave (
    input  pool_addr, pool_en,
    output pool_q,
    input  up_addr, up_en, up_we, up_d
  );
endinterface

// File: rtl/unpool2x_upsampler.sv
// Nearest-neighbour 2x2 upsampler: CHW pooled map -> CHW map of 2x size.
// Ports: clk, reset_n (async low), start, m (memory bus), busy, done.
module unpool2x_upsampler #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_SIZE    = 14
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  unpool2x_upsampler_if.master m,
  output logic busy,
  output logic done
);
  localparam int OUT_SIZE = 2 * IN_SIZE;
  localparam int N    = CHANNELS * IN_SIZE * IN_SIZE;
  localparam int PA_W = $clog2(N);
  localparam int UA_W = $clog2(4 * N);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE, PRIME, WR0, WR1, WR2, WR3, FINISH
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [UA_W-1:0] base_q, base_d;
  logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
  logic cap_q, cap_d;
  logic [PA_W-1:0] pool_addr_q, pool_addr_d;
  logic pool_en_q, pool_en_d;
  logic [UA_W-1:0] up_addr_q, up_addr_d;
  logic up_en_q, up_en_d;
  logic signed [DATA_WIDTH-1:0] up_d_q, up_d_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic last_col, last_row, last_ch, last;

  assign last_col = (col_q == IW'(IN_SIZE - 1));
  assign last_row = (row_q == IW'(IN_SIZE - 1));
  assign last_ch  = (ch_q == CW'(CHANNELS - 1));
  assign last     = last_col && last_row && last_ch;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    row_d       = row_q;
    col_d       = col_q;
    base_d      = base_q;
    hold_d      = hold_q;
    pool_addr_d = pool_addr_q;
    pool_en_d   = 1'b0;
    up_addr_d   = up_addr_q;
    up_en_d     = 1'b0;
    up_d_d      = up_d_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // read data lands one cycle after the enable
    cap_d       = pool_en_q;
    if (cap_q) hold_d = m.pool_q;
    unique case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          pool_en_d   = 1'b1;
          pool_addr_d = '0;
          ch_d        = '0;
          row_d       = '0;
          col_d       = '0;
          base_d      = '0;
          state_d     = PRIME;
        end
      end
      PRIME: begin
        if (cap_q) state_d = WR0;
      end
      WR0: begin
        up_en_d   = 1'b1;
        up_addr_d = base_q;
        up_d_d    = hold_q;
        // prefetch next element; it lands in hold during WR2
        if (!last) begin
          pool_en_d   = 1'b1;
          pool_addr_d = pool_addr_q + 1'b1;
        end
        state_d = WR1;
      end
      WR1: begin
        up_en_d   = 1'b1;
        up_addr_d = base_q + UA_W'(1);
        state_d   = WR2;
      end
      WR2: begin
        up_en_d   = 1'b1;
        up_addr_d = base_q + UA_W'(OUT_SIZE);
        state_d   = WR3;
      end
      WR3: begin
        up_en_d   = 1'b1;
        up_addr_d = base_q + UA_W'(OUT_SIZE + 1);
        // row and channel ends skip the odd output row
        base_d = base_q + (last_col ? UA_W'(OUT_SIZE + 2) : UA_W'(2));
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d = '0;
            ch_d  = last_ch ? '0 : ch_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
        state_d = last ? FINISH : WR0;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      base_q      <= '0;
      hold_q      <= '0;
      cap_q       <= 1'b0;
      pool_addr_q <= '0;
      pool_en_q   <= 1'b0;
      up_addr_q   <= '0;
      up_en_q     <= 1'b0;
      up_d_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      col_q       <= col_d;
      base_q      <= base_d;
      hold_q      <= hold_d;
      cap_q       <= cap_d;
      pool_addr_q <= pool_addr_d;
      pool_en_q   <= pool_en_d;
      up_addr_q   <= up_addr_d;
      up_en_q     <= up_en_d;
      up_d_q      <= up_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign m.pool_addr = pool_addr_q;
  assign m.pool_en   = pool_en_q;
  assign m.up_addr   = up_addr_q;
  assign m.up_en     = up_en_q;
  assign m.up_we     = up_en_q;
  assign m.up_d      = up_d_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule
